// File: rtl/flag_city_pkg.sv
// Shared types and constants for the flag_city scheduler slice.
// Action symbols, scheduler FSM states, walker destination and default LED word.
package flag_city_pkg;

  typedef enum logic [1:0] {
    ACT_FIT       = 2'b00,
    ACT_ATTACKED  = 2'b01,
    ACT_HURT      = 2'b10,
    ACT_NO_CHANGE = 2'b11
  } action_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_CLEAR = 3'd2,
    ST_FEED  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_JUDGE = 3'd5
  } sched_state_e;

  localparam logic [3:0]  DEST              = 4'd8;
  localparam logic [15:0] FLAG_WORD_DEFAULT = 16'hF1A6;

endpackage

// File: rtl/flag_city_rr_pick.sv
// Combinational round-robin picker: first eligible index at or above ptr,
// wrapping modulo N.
module flag_city_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     elig,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    any    = 1'b0;
    onehot = '0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      int               j;
      logic [IDX_W-1:0] jj;
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      jj = IDX_W'(j);
      if (!any && elig[jj]) begin
        any        = 1'b1;
        idx        = jj;
        onehot[jj] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/flag_city_sched.sv
// Round-robin scheduler sharing one flag_city walker between N_REQ players:
// grant, clear the walker, feed eight symbols, wait for the walker, then judge.
module flag_city_sched
  import flag_city_pkg::*;
#(
  parameter int          N_REQ     = 4,
  parameter int          SYM_CNT   = 8,
  parameter int          WALK_LAT  = 2,
  parameter logic [15:0] FLAG_WORD = FLAG_WORD_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [16*N_REQ-1:0]        status,
  output logic [N_REQ-1:0]           gnt,
  output logic                       walk_clr,
  output logic [1:0]                 walk_sym,
  output logic                       walk_vld,
  input  logic                       walk_dest,
  output logic                       done,
  output logic [$clog2(N_REQ)-1:0]   done_id,
  output logic                       done_pass,
  output logic [N_REQ-1:0]           pass_map,
  output logic [15:0]                flag_led
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int SYM_W = $clog2(SYM_CNT);
  localparam int DRN_W = (WALK_LAT > 1) ? $clog2(WALK_LAT) : 1;
  localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(SYM_CNT - 1);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'((WALK_LAT > 0) ? WALK_LAT - 1 : 0);

  sched_state_e      state_reg, state_next;
  logic [IDX_W-1:0]  id_reg;
  logic [IDX_W-1:0]  rr_ptr_reg;
  logic [N_REQ-1:0]  gnt_reg;
  logic [15:0]       word_reg;
  logic [SYM_W-1:0]  sym_cnt_reg;
  logic [DRN_W-1:0]  drn_cnt_reg;
  logic [N_REQ-1:0]  served_reg, served_next;
  logic [N_REQ-1:0]  pass_map_reg, pass_map_next;
  logic [15:0]       flag_led_reg;
  logic [N_REQ-1:0]  judge_hit;

  logic              pick_any;
  logic [N_REQ-1:0]  pick_onehot;
  logic [IDX_W-1:0]  pick_idx;

  flag_city_rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .elig   (req & ~served_reg),
    .ptr    (rr_ptr_reg),
    .any    (pick_any),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  // Judging sets the bit even if req already fell; a low req clears it otherwise.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_player
      assign judge_hit[gi]     = (state_reg == ST_JUDGE) && (id_reg == IDX_W'(gi));
      assign served_next[gi]   = judge_hit[gi] | (served_reg[gi] & req[gi]);
      assign pass_map_next[gi] = pass_map_reg[gi] | (judge_hit[gi] & walk_dest);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (pick_any) state_next = ST_GRANT;
      ST_GRANT: state_next = ST_CLEAR;
      ST_CLEAR: state_next = ST_FEED;
      ST_FEED:  if (sym_cnt_reg == SYM_LAST)
                  state_next = (WALK_LAT == 0) ? ST_JUDGE : ST_DRAIN;
      ST_DRAIN: if (drn_cnt_reg == DRN_LAST) state_next = ST_JUDGE;
      ST_JUDGE: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt       = (state_reg != ST_IDLE) ? gnt_reg : '0;
    walk_clr  = (state_reg == ST_CLEAR);
    walk_vld  = (state_reg == ST_FEED);
    walk_sym  = (state_reg == ST_FEED) ? word_reg[15:14] : 2'b00;
    done      = (state_reg == ST_JUDGE);
    done_id   = (state_reg == ST_JUDGE) ? id_reg : '0;
    done_pass = (state_reg == ST_JUDGE) & walk_dest;
    pass_map  = pass_map_reg;
    flag_led  = flag_led_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_reg       <= '0;
      rr_ptr_reg   <= '0;
      gnt_reg      <= '0;
      word_reg     <= '0;
      sym_cnt_reg  <= '0;
      drn_cnt_reg  <= '0;
      served_reg   <= '0;
      pass_map_reg <= '0;
      flag_led_reg <= '0;
    end else begin
      if (state_reg == ST_IDLE && pick_any) begin
        id_reg  <= pick_idx;
        gnt_reg <= pick_onehot;
      end
      // Word is shifted out MSB pair first, so the feed stage only looks at [15:14].
      if (state_reg == ST_GRANT)
        word_reg <= status[{id_reg, 4'b0000} +: 16];
      else if (state_reg == ST_FEED)
        word_reg <= word_reg << 2;

      if (state_reg == ST_FEED)
        sym_cnt_reg <= (sym_cnt_reg == SYM_LAST) ? '0 : sym_cnt_reg + 1'b1;
      else
        sym_cnt_reg <= '0;

      if (state_reg == ST_DRAIN)
        drn_cnt_reg <= (drn_cnt_reg == DRN_LAST) ? '0 : drn_cnt_reg + 1'b1;
      else
        drn_cnt_reg <= '0;

      if (state_reg == ST_JUDGE)
        rr_ptr_reg <= (id_reg == IDX_W'(N_REQ - 1)) ? '0 : id_reg + 1'b1;

      served_reg   <= served_next;
      pass_map_reg <= pass_map_next;
      flag_led_reg <= (|pass_map_reg) ? FLAG_WORD : 16'h0000;
    end
  end

endmodule

// File: tb/tb_flag_city_sched.sv
// Self-checking bench for flag_city_sched: walker model, service-timeline model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_flag_city_sched;
  import flag_city_pkg::*;

  localparam int N  = 4;
  localparam int WL = 2;
  localparam int JT = 2 + 8 + WL;   // cycles from grant to judge

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req = '0;
  logic [16*N-1:0]   status = '0;
  logic [N-1:0]      gnt;
  logic              walk_clr;
  logic [1:0]        walk_sym;
  logic              walk_vld;
  logic              walk_dest;
  logic              done;
  logic [1:0]        done_id;
  logic              done_pass;
  logic [N-1:0]      pass_map;
  logic [15:0]       flag_led;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  flag_city_sched #(.N_REQ(N), .SYM_CNT(8), .WALK_LAT(WL), .FLAG_WORD(16'hF1A6)) dut (
    .clk(clk), .rst(rst), .req(req), .status(status), .gnt(gnt),
    .walk_clr(walk_clr), .walk_sym(walk_sym), .walk_vld(walk_vld),
    .walk_dest(walk_dest), .done(done), .done_id(done_id), .done_pass(done_pass),
    .pass_map(pass_map), .flag_led(flag_led)
  );

  // Walker: attacked moves two squares, hurt one, others stay; saturates at 15.
  function automatic int sym_weight(logic [1:0] s);
    case (s)
      ACT_ATTACKED: return 2;
      ACT_HURT:     return 1;
      default:      return 0;
    endcase
  endfunction

  int   wpos  = 0;
  logic wdest = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      wpos  <= 0;
      wdest <= 1'b0;
    end else begin
      if (walk_clr)      wpos <= 0;
      else if (walk_vld) wpos <= (wpos + sym_weight(walk_sym) > 15) ? 15 : wpos + sym_weight(walk_sym);
      wdest <= (wpos == int'(DEST));
    end
  end
  assign walk_dest = wdest;

  function automatic bit walk_ok(logic [15:0] w);
    int p;
    p = 0;
    for (int k = 0; k < 8; k++) begin
      p = p + sym_weight(2'((w >> (14 - 2 * k)) & 16'h3));
      if (p > 15) p = 15;
    end
    return p == int'(DEST);
  endfunction

  // Service-timeline model: m_phase = -1 idle, else cycles since grant.
  int          m_phase = -1;
  int          m_id    = 0;
  int          m_rr    = 0;
  logic [15:0] m_word  = '0;
  bit          m_served [N];
  bit          m_pass   [N];
  logic [15:0] m_led   = '0;

  always @(posedge clk) begin
    int ph;
    bit found;
    bit anyp;
    if (rst) begin
      m_phase = -1;
      m_rr    = 0;
      m_led   = '0;
      for (int i = 0; i < N; i++) begin m_served[i] = 0; m_pass[i] = 0; end
    end else begin
      ph    = m_phase;
      anyp  = 0;
      for (int i = 0; i < N; i++) anyp |= m_pass[i];
      m_led = anyp ? 16'hF1A6 : 16'h0000;
      found = 0;
      if (ph == -1) begin
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_rr + k) % N;
          if (!found && req[j] && !m_served[j]) begin found = 1; m_id = j; end
        end
      end
      for (int i = 0; i < N; i++) if (!req[i]) m_served[i] = 0;
      if (ph == JT) begin
        m_served[m_id] = 1;
        if (walk_ok(m_word)) m_pass[m_id] = 1;
        m_rr = (m_id + 1) % N;
      end
      if (ph == -1)      m_phase = found ? 0 : -1;
      else if (ph == 0)  begin m_word = status[16*m_id +: 16]; m_phase = 1; end
      else if (ph == JT) m_phase = -1;
      else               m_phase = ph + 1;
    end
  end

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Per-cycle compare plus transaction monitors.
  int q_sym [$];
  int q_id  [$];
  int q_pas [$];
  int gnt_cycles  = 0;
  int grant_seen  = 0;
  logic [N-1:0] prev_gnt = '0;

  always @(negedge clk) begin
    logic [N-1:0] eg;
    logic [1:0]   es;
    logic [N-1:0] ep;
    int p;
    p  = m_phase;
    eg = (p >= 0) ? N'(1 << m_id) : '0;
    es = (p >= 2 && p <= 9) ? 2'((m_word >> (14 - 2 * (p - 2))) & 16'h3) : 2'b00;
    for (int i = 0; i < N; i++) ep[i] = m_pass[i];
    chk("gnt",       32'(gnt),       32'(eg));
    chk("walk_clr",  32'(walk_clr),  32'(p == 1));
    chk("walk_vld",  32'(walk_vld),  32'(p >= 2 && p <= 9));
    chk("walk_sym",  32'(walk_sym),  32'(es));
    chk("done",      32'(done),      32'(p == JT));
    chk("done_id",   32'(done_id),   (p == JT) ? 32'(m_id) : 32'd0);
    chk("done_pass", 32'(done_pass), (p == JT) ? 32'(walk_ok(m_word)) : 32'd0);
    chk("pass_map",  32'(pass_map),  32'(ep));
    chk("flag_led",  32'(flag_led),  32'(m_led));
    if (walk_vld) q_sym.push_back(int'(walk_sym));
    if (gnt != '0) gnt_cycles++;
    if (prev_gnt == '0 && gnt != '0) grant_seen++;
    prev_gnt = gnt;
    if (done) begin q_id.push_back(int'(done_id)); q_pas.push_back(int'(done_pass)); end
    if (!(done === 1'b1 || done === 1'b0)) begin end
    $display("cyc t=%0t rst=%b req=%b gnt=%b vld=%b sym=%0d done=%b id=%0d pass=%b map=%b led=%h",
             $time, rst, req, gnt, walk_vld, walk_sym, done, done_id, done_pass, pass_map, flag_led);
  end

  task automatic tick(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_mon();
    q_sym.delete(); q_id.delete(); q_pas.delete();
    gnt_cycles = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0;
    tick(2);
    rst = 1'b0;
    clear_mon();
  endtask

  task automatic wait_done(int target, int budget, string nm);
    int c;
    c = 0;
    while (q_id.size() < target && c < budget) begin @(negedge clk); c++; end
    total++;
    if (q_id.size() < target) begin
      bad++;
      $display("FAIL %s: timeout, got %0d done pulses, expected %0d", nm, q_id.size(), target);
    end
    tick(1);
  endtask

  task automatic wait_grant(int budget, string nm);
    int c, s;
    c = 0; s = grant_seen;
    while (grant_seen == s && c < budget) begin @(negedge clk); c++; end
    total++;
    if (grant_seen == s) begin
      bad++;
      $display("FAIL %s: timeout waiting for grant", nm);
    end
  endtask

  task automatic chk_syms_5182(string nm);
    int exp_s [8];
    exp_s = '{1, 1, 0, 1, 2, 0, 0, 2};
    chk({nm, "_nsym"}, 32'(q_sym.size()), 32'd8);
    for (int k = 0; k < 8 && k < q_sym.size(); k++)
      chk({nm, "_sym"}, 32'(q_sym[k]), 32'(exp_s[k]));
  endtask

  initial begin
    // 1: single winner
    do_reset();
    status[15:0] = 16'h5182; req = 4'b0001;
    wait_done(1, 40, "t1_done");
    chk_syms_5182("t1");
    chk("t1_gnt_cycles", 32'(gnt_cycles), 32'd13);
    if (q_pas.size() > 0) chk("t1_pass", 32'(q_pas[0]), 32'd1);
    tick(2);
    chk("t1_pass_map", 32'(pass_map), 32'h1);
    chk("t1_flag_led", 32'(flag_led), 32'hF1A6);
    req = '0;

    // 2: failing player
    do_reset();
    status[31:16] = 16'h0000; req = 4'b0010;
    wait_done(1, 40, "t2_done");
    if (q_id.size() > 0) begin
      chk("t2_id", 32'(q_id[0]), 32'd1);
      chk("t2_pass", 32'(q_pas[0]), 32'd0);
    end
    tick(2);
    chk("t2_pass_map", 32'(pass_map), 32'h0);
    chk("t2_flag_led", 32'(flag_led), 32'h0);
    req = '0;

    // 3: round robin, no re-grant until req drops
    do_reset();
    status = '0; req = 4'b1111;
    wait_done(4, 80, "t3_done");
    for (int i = 0; i < 4 && i < q_id.size(); i++) chk("t3_order", 32'(q_id[i]), 32'(i));
    tick(30);
    chk("t3_no_regrant", 32'(q_id.size()), 32'd4);
    req = 4'b1110; tick(1); req = 4'b1111;
    wait_done(5, 40, "t3_regrant");
    if (q_id.size() > 4) chk("t3_regrant_id", 32'(q_id[4]), 32'd0);
    req = '0; tick(2);

    // 4: wrap with simultaneous requests
    clear_mon();
    req = 4'b0100;
    wait_done(1, 40, "t4_p2");
    req = 4'b1001;
    wait_done(3, 60, "t4_pair");
    if (q_id.size() > 2) begin
      chk("t4_first", 32'(q_id[1]), 32'd3);
      chk("t4_second", 32'(q_id[2]), 32'd0);
    end
    req = '0; tick(2);

    // 5: status changes after grant
    do_reset();
    status[15:0] = 16'h5182; req = 4'b0001;
    wait_grant(20, "t5_grant");
    tick(3);
    status[15:0] = 16'h0000;
    wait_done(1, 40, "t5_done");
    chk_syms_5182("t5");
    if (q_pas.size() > 0) chk("t5_pass", 32'(q_pas[0]), 32'd1);
    req = '0; tick(2);

    // 6: reset during feed
    clear_mon();
    status[15:0] = 16'h5182; req = 4'b0001;
    wait_grant(20, "t6_grant");
    tick(5);
    rst = 1'b1; req = 4'b1001;
    @(negedge clk); @(negedge clk);
    chk("t6_gnt", 32'(gnt), 32'h0);
    chk("t6_vld", 32'(walk_vld), 32'h0);
    chk("t6_pass_map", 32'(pass_map), 32'h0);
    chk("t6_no_done", 32'(q_id.size()), 32'd0);
    tick(1);
    rst = 1'b0;
    wait_done(1, 40, "t6_after");
    if (q_id.size() > 0) chk("t6_first_id", 32'(q_id[0]), 32'd0);
    req = '0; tick(2);

    // randomized traffic, checked by the per-cycle model
    for (int it = 0; it < 250; it++) begin
      for (int i = 0; i < N; i++) begin
        int r;
        r = $urandom_range(0, 3);
        case (r)
          0: status[16*i +: 16] = 16'h5182;
          1: status[16*i +: 16] = 16'h5500;
          2: status[16*i +: 16] = 16'h0000;
          default: status[16*i +: 16] = 16'($urandom());
        endcase
      end
      req = N'($urandom());
      rst = ($urandom_range(0, 39) == 0);
      tick(1);
      rst = 1'b0;
      tick($urandom_range(1, 30));
    end
    req = '0; tick(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
